// File: rtl/scandoubler_rotate_port_if.sv
// Bus bundle between the rotating scandoubler, this memory port and one SDRAM client port.
// The slave modport is the port itself; the master modport is the surrounding environment.
interface scandoubler_rotate_port_if #(
  parameter int HCNT_WIDTH = 10
);
  localparam int AW = 2 * HCNT_WIDTH + 1;

  logic                  vidin_req;
  logic                  vidin_frame;
  logic [HCNT_WIDTH-1:0] vidin_row;
  logic [HCNT_WIDTH-1:0] vidin_col;
  logic [15:0]           vidin_d;
  logic                  vidin_ack;

  logic                  vidout_req;
  logic                  vidout_frame;
  logic [HCNT_WIDTH-1:0] vidout_row;
  logic [HCNT_WIDTH-1:0] vidout_col;
  logic [15:0]           vidout_d;
  logic                  vidout_ack;

  logic                  mem_req;
  logic                  mem_we;
  logic [AW-1:0]         mem_addr;
  logic [15:0]           mem_d;
  logic [15:0]           mem_q;
  logic                  mem_ack;

  modport slave (
    input  vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    output vidin_ack,
    input  vidout_req, vidout_frame, vidout_row, vidout_col,
    output vidout_d, vidout_ack,
    output mem_req, mem_we, mem_addr, mem_d,
    input  mem_q, mem_ack
  );

  modport master (
    output vidin_req, vidin_frame, vidin_row, vidin_col, vidin_d,
    input  vidin_ack,
    output vidout_req, vidout_frame, vidout_row, vidout_col,
    input  vidout_d, vidout_ack,
    input  mem_req, mem_we, mem_addr, mem_d,
    output mem_q, mem_ack
  );
endinterface

// File: rtl/scandoubler_rotate_port.sv
// Responder-side memory port for the rotating scandoubler: maps 16-word write bursts and
// per-row read streams onto one single-word SDRAM port with transposed (cornerturn) addressing.
module scandoubler_rotate_port #(
  parameter int HCNT_WIDTH = 10
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  scandoubler_rotate_port_if.slave bus
);
  localparam int AW = 2 * HCNT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [1:0]    holdoff_q, holdoff_d;
  logic [3:0]    wcount_q, wcount_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]   mem_d_q, mem_d_d;
  logic [15:0]   vidout_d_q, vidout_d_d;
  logic          vidin_ack_q, vidin_ack_d;
  logic          vidout_ack_q, vidout_ack_d;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      holdoff_q    <= '0;
      wcount_q     <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_d_q      <= '0;
      vidout_d_q   <= '0;
      vidin_ack_q  <= 1'b0;
      vidout_ack_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      holdoff_q    <= holdoff_d;
      wcount_q     <= wcount_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_d_q      <= mem_d_d;
      vidout_d_q   <= vidout_d_d;
      vidin_ack_q  <= vidin_ack_d;
      vidout_ack_q <= vidout_ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    holdoff_d    = holdoff_q;
    wcount_d     = wcount_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_d_d      = mem_d_q;
    vidout_d_d   = vidout_d_q;
    vidin_ack_d  = 1'b0;
    vidout_ack_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Writes win every word boundary; a partially sent burst blocks reads until it is abandoned.
        if (holdoff_q != 2'd0) begin
          holdoff_d = holdoff_q - 2'd1;
        end else if (bus.vidin_req) begin
          mem_addr_d = {bus.vidin_frame, bus.vidin_col, bus.vidin_row};
          mem_d_d    = bus.vidin_d;
          mem_we_d   = 1'b1;
          mem_req_d  = 1'b1;
          state_d    = WR_WAIT;
        end else if (wcount_q != 4'd0) begin
          wcount_d = 4'd0;
        end else if (bus.vidout_req) begin
          mem_addr_d = {bus.vidout_frame, bus.vidout_row, bus.vidout_col};
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          state_d    = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          vidin_ack_d = 1'b1;
          wcount_d    = wcount_q + 4'd1;
          holdoff_d   = 2'd1;
          state_d     = HOLD;
        end
      end
      RD_WAIT: begin
        if (bus.mem_ack) begin
          mem_req_d    = 1'b0;
          vidout_d_d   = bus.mem_q;
          vidout_ack_d = 1'b1;
          holdoff_d    = 2'd1;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // Ack cycle plus one more, so IDLE samples the initiator only after its request/data update.
        if (holdoff_q != 2'd0) begin
          holdoff_d = holdoff_q - 2'd1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.vidin_ack  = vidin_ack_q;
  assign bus.vidout_ack = vidout_ack_q;
  assign bus.vidout_d   = vidout_d_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_d      = mem_d_q;

endmodule

// File: tb/tb_scandoubler_rotate_port.sv
// Self-checking bench for scandoubler_rotate_port: randomized data and latencies checked against
// an image-level cornerturn model and an expected memory access sequence.
module tb_scandoubler_rotate_port;
  logic clk_sys;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  int   mem_lat;

  typedef struct {
    bit          we;
    int          addr;
    logic [15:0] d;
    logic [15:0] q;
    int          cyc;
  } acc_t;

  typedef struct {
    bit          we;
    int          addr;
    logic [15:0] d;
  } exp_t;

  acc_t        acc_log[$];
  exp_t        exp_q[$];
  int          ack_cyc[$];
  logic [15:0] mem_arr[int];
  logic [15:0] img[int];
  logic [15:0] wdata_arr[16];
  logic [15:0] last_rd;

  scandoubler_rotate_port_if #(.HCNT_WIDTH(10)) sif ();

  scandoubler_rotate_port #(.HCNT_WIDTH(10)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (sif)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    cyc = 0;
    forever @(posedge clk_sys) cyc++;
  end

  function automatic logic [15:0] fill(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  function automatic int wr_addr(input int f, input int x, input int y);
    return (f << 20) | (x << 10) | y;
  endfunction

  function automatic int rd_addr(input int f, input int row, input int col);
    return (f << 20) | (row << 10) | col;
  endfunction

  // A pixel (x, y) read back as row = x, col = y; unwritten memory returns fill(address).
  function automatic logic [15:0] exp_pixel(input int f, input int x, input int y);
    int key;
    key = wr_addr(f, x, y);
    if (img.exists(key)) return img[key];
    return fill(rd_addr(f, x, y));
  endfunction

  // Memory with a fixed latency; an access abandoned by the port is never acknowledged.
  initial begin : mem_model
    acc_t a;
    bit   alive;
    int   lat;
    sif.mem_ack = 1'b0;
    sif.mem_q   = 16'h0;
    forever begin
      @(negedge clk_sys);
      if (reset_n && sif.mem_req) begin
        a.we   = sif.mem_we;
        a.addr = int'(sif.mem_addr);
        a.d    = sif.mem_d;
        a.cyc  = cyc;
        a.q    = 16'h0;
        lat    = mem_lat;
        alive  = 1'b1;
        for (int k = 1; k < lat; k++) begin
          @(negedge clk_sys);
          if (!sif.mem_req) alive = 1'b0;
        end
        @(posedge clk_sys);
        #1;
        if (alive && sif.mem_req) begin
          if (a.we) mem_arr[a.addr] = a.d;
          else a.q = mem_arr.exists(a.addr) ? mem_arr[a.addr] : fill(a.addr);
          sif.mem_q   = a.q;
          sif.mem_ack = 1'b1;
          acc_log.push_back(a);
          @(posedge clk_sys);
          #1;
          sif.mem_ack = 1'b0;
          sif.mem_q   = 16'($urandom);
        end
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_wr(input int addr, input logic [15:0] d);
    exp_t e;
    e.we = 1'b1; e.addr = addr; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input int addr);
    exp_t e;
    e.we = 1'b0; e.addr = addr; e.d = 16'h0;
    exp_q.push_back(e);
  endtask

  task automatic check_log(input string tag);
    check_output({tag, "_count"}, acc_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++) begin
      check_output($sformatf("%s_acc%0d", tag, i),
                   (acc_log[i].we ? 32'h0100_0000 : 32'h0) | acc_log[i].addr,
                   (exp_q[i].we ? 32'h0100_0000 : 32'h0) | exp_q[i].addr);
      if (exp_q[i].we)
        check_output($sformatf("%s_wd%0d", tag, i), acc_log[i].d, exp_q[i].d);
    end
  endtask

  task automatic apply_stimulus(input string tag, input int n_wr, input int wr_trig, input int wf,
                                input int wrow, input int wcol0, input int n_rd, input int rf,
                                input int rrow, input int rcol0, input int budget);
    int wd = 0;
    int rd = 0;
    int cycles = 0;
    bit wr_on, w_acked, r_acked, trig;
    acc_log.delete();
    ack_cyc.delete();
    wr_on = (n_wr > 0) && (wr_trig < 0);
    sif.vidin_frame  = wf[0];
    sif.vidin_row    = wrow[9:0];
    sif.vidin_col    = wcol0[9:0];
    sif.vidin_d      = wdata_arr[0];
    sif.vidin_req    = wr_on;
    sif.vidout_frame = rf[0];
    sif.vidout_row   = rrow[9:0];
    sif.vidout_col   = rcol0[9:0];
    sif.vidout_req   = (n_rd > 0);
    while ((wd < n_wr || rd < n_rd) && cycles < budget) begin
      @(negedge clk_sys);
      cycles++;
      w_acked = sif.vidin_ack;
      r_acked = sif.vidout_ack;
      trig    = 1'b0;
      if (w_acked) begin
        img[wr_addr(wf, wcol0 + wd, wrow)] = wdata_arr[wd];
        ack_cyc.push_back(cyc);
        wd++;
      end
      if (r_acked) begin
        check_output($sformatf("%s_rd%0d", tag, rd), sif.vidout_d, exp_pixel(rf, rrow, rcol0 + rd));
        last_rd = sif.vidout_d;
        rd++;
      end
      if (!wr_on && n_wr > 0 && rd == wr_trig && sif.mem_req && !sif.mem_we) trig = 1'b1;
      @(posedge clk_sys);
      #1;
      if (trig) begin
        sif.vidin_req = 1'b1;
        wr_on = 1'b1;
      end
      if (w_acked) begin
        if (wd < n_wr) begin
          sif.vidin_col = 10'(wcol0 + wd);
          sif.vidin_d   = wdata_arr[wd];
        end else begin
          sif.vidin_req = 1'b0;
        end
      end
      if (r_acked) begin
        if (rd < n_rd) sif.vidout_col = 10'(rcol0 + rd);
        else sif.vidout_req = 1'b0;
      end
    end
    check_output({tag, "_in_budget"}, 32'(cycles < budget), 32'd1);
  endtask

  initial begin : main
    bit saw_ack, found;
    int lat;
    checks  = 0;
    errors  = 0;
    mem_lat = 2;
    last_rd = 16'h0;

    // Reset held with both requests high
    reset_n          = 1'b0;
    sif.vidin_req    = 1'b1;
    sif.vidin_frame  = 1'b1;
    sif.vidin_row    = 10'd50;
    sif.vidin_col    = 10'd60;
    sif.vidin_d      = 16'h1234;
    sif.vidout_req   = 1'b1;
    sif.vidout_frame = 1'b0;
    sif.vidout_row   = 10'd1;
    sif.vidout_col   = 10'd1;
    repeat (3) @(negedge clk_sys);
    check_output("rst_vidin_ack", sif.vidin_ack, 0);
    check_output("rst_vidout_ack", sif.vidout_ack, 0);
    check_output("rst_mem_req", sif.mem_req, 0);
    check_output("rst_mem_we", sif.mem_we, 0);
    check_output("rst_mem_addr", sif.mem_addr, 0);
    check_output("rst_mem_d", sif.mem_d, 0);
    check_output("rst_vidout_d", sif.vidout_d, 0);
    reset_n = 1'b1;
    #1;
    check_output("rst_req_at_release", sif.mem_req, 0);
    @(negedge clk_sys);
    check_output("rst_first_req", sif.mem_req, 1);
    check_output("rst_first_we", sif.mem_we, 1);
    check_output("rst_first_addr", sif.mem_addr, wr_addr(1, 60, 50));
    check_output("rst_first_d", sif.mem_d, 16'h1234);
    reset_n        = 1'b0;
    sif.vidin_req  = 1'b0;
    sif.vidout_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(posedge clk_sys);
    #1;

    // Single burst, fixed latency 3
    mem_lat = 3;
    foreach (wdata_arr[i]) wdata_arr[i] = 16'($urandom);
    apply_stimulus("burst", 16, -1, 1, 5, 32, 0, 0, 0, 0, 300);
    exp_q.delete();
    for (int c = 0; c < 16; c++) push_wr(wr_addr(1, 32 + c, 5), wdata_arr[c]);
    check_log("burst");
    check_output("burst_ack_count", ack_cyc.size(), 16);
    for (int i = 1; i < ack_cyc.size(); i++)
      check_output($sformatf("burst_period%0d", i), ack_cyc[i] - ack_cyc[i-1], 7);
    if (acc_log.size() > 1 && ack_cyc.size() > 0)
      check_output("burst_relaunch_gap", acc_log[1].cyc - ack_cyc[0], 3);

    // Full row fetch with random latency
    mem_lat = $urandom_range(1, 4);
    apply_stimulus("fetch", 0, -1, 0, 0, 0, 240, 0, 100, 0, 3000);
    exp_q.delete();
    for (int c = 0; c < 240; c++) push_rd(rd_addr(0, 100, c));
    check_log("fetch");

    // Write burst arriving while read word 10 is in flight
    mem_lat = $urandom_range(1, 3);
    foreach (wdata_arr[i]) wdata_arr[i] = 16'($urandom);
    apply_stimulus("midfetch", 16, 10, 1, 9, 0, 20, 0, 200, 0, 800);
    exp_q.delete();
    for (int c = 0; c <= 10; c++) push_rd(rd_addr(0, 200, c));
    for (int c = 0; c < 16; c++) push_wr(wr_addr(1, c, 9), wdata_arr[c]);
    for (int c = 11; c < 20; c++) push_rd(rd_addr(0, 200, c));
    check_log("midfetch");

    // Short burst abandoned after 5 words: lock costs one idle cycle before the read
    mem_lat = 2;
    foreach (wdata_arr[i]) wdata_arr[i] = 16'($urandom);
    apply_stimulus("lock", 5, -1, 0, 12, 100, 3, 0, 101, 12, 200);
    exp_q.delete();
    for (int c = 0; c < 5; c++) push_wr(wr_addr(0, 100 + c, 12), wdata_arr[c]);
    for (int c = 12; c < 15; c++) push_rd(rd_addr(0, 101, c));
    check_log("lock");
    if (acc_log.size() > 5 && ack_cyc.size() == 5)
      check_output("lock_gap", acc_log[5].cyc - ack_cyc[4], 4);

    // Cornerturn round trip
    mem_lat = $urandom_range(1, 4);
    wdata_arr[0] = 16'hF81F;
    apply_stimulus("ct_wr", 1, -1, 0, 3, 7, 0, 0, 0, 0, 50);
    apply_stimulus("ct_rd", 0, -1, 0, 0, 0, 1, 0, 7, 3, 50);
    check_output("ct_value", last_rd, 16'hF81F);

    // Reset while a write waits on memory
    mem_lat = 4;
    acc_log.delete();
    lat = 16'($urandom);
    sif.vidin_frame = 1'b1;
    sif.vidin_row   = 10'd2;
    sif.vidin_col   = 10'd9;
    sif.vidin_d     = 16'(lat);
    sif.vidin_req   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_sys);
      if (sif.mem_req) found = 1'b1;
    end
    check_output("rstmid_launch", found, 1);
    reset_n = 1'b0;
    #1;
    check_output("rstmid_req_drop", sif.mem_req, 0);
    saw_ack = 1'b0;
    repeat (3) begin
      @(negedge clk_sys);
      if (sif.vidin_ack) saw_ack = 1'b1;
    end
    reset_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk_sys);
      if (sif.vidin_ack) found = 1'b1;
    end
    @(posedge clk_sys);
    #1;
    sif.vidin_req = 1'b0;
    check_output("rstmid_no_ack_in_reset", saw_ack, 0);
    check_output("rstmid_retry_ack", found, 1);
    exp_q.delete();
    push_wr(wr_addr(1, 9, 2), 16'(lat));
    check_log("rstmid");

    repeat (4) @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
